// File: rtl/wfg_mem_pkg.sv
// Shared types and constants for the waveform-pattern memory writer.
// The read-back states exist only when WFG_MEM_WRITER_READBACK_EN is defined.
package wfg_mem_pkg;

    localparam int BANK_ADDR_W    = 9;
    localparam int DATA_W         = 32;
    localparam int SEL_W          = 4;
    localparam int BANK_SEL_BIT   = 11;
    localparam int WINDOW_MSB_LSB = 12;

    typedef enum logic [2:0] {
        IDLE,
        WR,
`ifdef WFG_MEM_WRITER_READBACK_EN
        RD_ISSUE,
        RD_WAIT,
`endif
        ACK
    } wfg_state_t;

endpackage

// File: rtl/wfg_mem_writer_if.sv
// Wishbone classic slave bus used to reach the pattern memory writer.
interface wfg_mem_writer_if;
    import wfg_mem_pkg::*;

    logic              io_wbs_cyc;
    logic              io_wbs_stb;
    logic              io_wbs_we;
    logic [SEL_W-1:0]  io_wbs_sel;
    logic [31:0]       io_wbs_adr;
    logic [DATA_W-1:0] io_wbs_datwr;
    logic [DATA_W-1:0] io_wbs_datrd;
    logic              io_wbs_ack;

    modport master (
        output io_wbs_cyc, io_wbs_stb, io_wbs_we, io_wbs_sel, io_wbs_adr, io_wbs_datwr,
        input  io_wbs_datrd, io_wbs_ack
    );

    modport slave (
        input  io_wbs_cyc, io_wbs_stb, io_wbs_we, io_wbs_sel, io_wbs_adr, io_wbs_datwr,
        output io_wbs_datrd, io_wbs_ack
    );

endinterface

// File: rtl/wfg_mem_writer.sv
// Wishbone slave writing the two 32x512 pattern SRAM banks through port 0.
// Define WFG_MEM_WRITER_READBACK_EN to read SRAM contents back over Wishbone.
module wfg_mem_writer
    import wfg_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3010_0000
) (
    input  logic                   io_wbs_clk,
    input  logic                   io_wbs_rst_n,
    wfg_mem_writer_if.slave        wbs,
    output logic                   csb0_mem0,
    output logic                   csb0_mem1,
    output logic                   web0,
    output logic [SEL_W-1:0]       wmask0,
    output logic [BANK_ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0]      din0,
    input  logic [DATA_W-1:0]      dout0_mem0,
    input  logic [DATA_W-1:0]      dout0_mem1
);

    wfg_state_t state, state_nxt;

    logic                   csb0_nxt, csb1_nxt, web_nxt, ack_nxt;
    logic [SEL_W-1:0]       wmask_nxt;
    logic [BANK_ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0]      din_nxt, datrd_nxt;
    logic [DATA_W-1:0]      datrd_q;
    logic                   ack_q;
    logic                   hit;
    logic                   bank_sel;

`ifdef WFG_MEM_WRITER_READBACK_EN
    logic bank_q, bank_nxt;
    logic unused_bits;
    assign unused_bits = ^wbs.io_wbs_adr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{wbs.io_wbs_adr[1:0], dout0_mem0, dout0_mem1};
`endif

    assign hit = wbs.io_wbs_cyc & wbs.io_wbs_stb &
                 (wbs.io_wbs_adr[31:WINDOW_MSB_LSB] == BASE_ADDR[31:WINDOW_MSB_LSB]);
    assign bank_sel = wbs.io_wbs_adr[BANK_SEL_BIT];

    assign wbs.io_wbs_ack   = ack_q;
    assign wbs.io_wbs_datrd = datrd_q;

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            state     <= IDLE;
            csb0_mem0 <= 1'b1;
            csb0_mem1 <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din0      <= '0;
            ack_q     <= 1'b0;
            datrd_q   <= '0;
`ifdef WFG_MEM_WRITER_READBACK_EN
            bank_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            csb0_mem0 <= csb0_nxt;
            csb0_mem1 <= csb1_nxt;
            web0      <= web_nxt;
            wmask0    <= wmask_nxt;
            addr0     <= addr_nxt;
            din0      <= din_nxt;
            ack_q     <= ack_nxt;
            datrd_q   <= datrd_nxt;
`ifdef WFG_MEM_WRITER_READBACK_EN
            bank_q    <= bank_nxt;
`endif
        end
    end

    // Every SRAM strobe is registered, so decisions made here show up one cycle later.
    always_comb begin
        state_nxt = state;
        csb0_nxt  = 1'b1;
        csb1_nxt  = 1'b1;
        web_nxt   = 1'b1;
        wmask_nxt = '0;
        addr_nxt  = addr0;
        din_nxt   = din0;
        ack_nxt   = 1'b0;
        datrd_nxt = datrd_q;
`ifdef WFG_MEM_WRITER_READBACK_EN
        bank_nxt  = bank_q;
`endif
        case (state)
            IDLE: begin
                if (hit) begin
                    if (wbs.io_wbs_we) begin
                        state_nxt = WR;
                        csb0_nxt  = bank_sel;
                        csb1_nxt  = ~bank_sel;
                        web_nxt   = 1'b0;
                        wmask_nxt = wbs.io_wbs_sel;
                        din_nxt   = wbs.io_wbs_datwr;
                        addr_nxt  = wbs.io_wbs_adr[BANK_ADDR_W+1:2];
                        ack_nxt   = 1'b1;
                    end else begin
`ifdef WFG_MEM_WRITER_READBACK_EN
                        state_nxt = RD_ISSUE;
                        csb0_nxt  = bank_sel;
                        csb1_nxt  = ~bank_sel;
                        addr_nxt  = wbs.io_wbs_adr[BANK_ADDR_W+1:2];
                        bank_nxt  = bank_sel;
`else
                        state_nxt = ACK;
                        ack_nxt   = 1'b1;
                        datrd_nxt = '0;
`endif
                    end
                end
            end
            WR:       state_nxt = IDLE;
`ifdef WFG_MEM_WRITER_READBACK_EN
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                state_nxt = ACK;
                datrd_nxt = bank_q ? dout0_mem1 : dout0_mem0;
                ack_nxt   = 1'b1;
            end
`endif
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wfg_mem_writer.sv
// Scoreboard bench for wfg_mem_writer with a behavioural model of both SRAM banks.
// Read expectations follow WFG_MEM_WRITER_READBACK_EN.
module tb_wfg_mem_writer;

`ifdef WFG_MEM_WRITER_READBACK_EN
    localparam int  RD_LAT = 2;
    localparam bit  RB     = 1'b1;
`else
    localparam int  RD_LAT = 0;
    localparam bit  RB     = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        csb0_mem0, csb0_mem1, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0, dout0_mem0, dout0_mem1;

    wfg_mem_writer_if wbs ();

    wfg_mem_writer #(.BASE_ADDR(32'h3010_0000)) dut (
        .io_wbs_clk   (clk),
        .io_wbs_rst_n (rst_n),
        .wbs          (wbs),
        .csb0_mem0    (csb0_mem0),
        .csb0_mem1    (csb0_mem1),
        .web0         (web0),
        .wmask0       (wmask0),
        .addr0        (addr0),
        .din0         (din0),
        .dout0_mem0   (dout0_mem0),
        .dout0_mem1   (dout0_mem1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM model: masked write, read data appears one cycle after the strobe.
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];
    always @(posedge clk) begin
        if (!csb0_mem0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem0[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                dout0_mem0 <= mem0[addr0];
            end
        end
        if (!csb0_mem1) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem1[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                dout0_mem1 <= mem1[addr0];
            end
        end
    end

    typedef struct {
        int unsigned cyc;
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wbs.io_wbs_ack) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc_cnt != e.cyc) begin
                    n_fail++;
                    $display("FAIL ack_cycle: got %0d expected %0d", cyc_cnt, e.cyc);
                end else if (e.is_rd && wbs.io_wbs_datrd !== e.data) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", wbs.io_wbs_datrd, e.data);
                end
            end
        end
    end

    // Issues one request; returns with the clock #1 into the cycle after it was sampled.
    task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output int unsigned s);
        @(posedge clk); #1;
        wbs.io_wbs_cyc   = 1'b1;
        wbs.io_wbs_stb   = 1'b1;
        wbs.io_wbs_we    = we;
        wbs.io_wbs_adr   = adr;
        wbs.io_wbs_sel   = sel;
        wbs.io_wbs_datwr = dat;
        s = cyc_cnt + 1;
        @(posedge clk); #1;
        wbs.io_wbs_cyc = 1'b0;
        wbs.io_wbs_stb = 1'b0;
    endtask

    task automatic expect_ack(input int unsigned c, input logic is_rd, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.is_rd = is_rd; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        for (int i = 0; i < 512; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[4] = 32'h1234_5678;
        dout0_mem0 = '0;
        dout0_mem1 = '0;
        wbs.io_wbs_cyc = 0; wbs.io_wbs_stb = 0; wbs.io_wbs_we = 0;
        wbs.io_wbs_sel = '0; wbs.io_wbs_adr = '0; wbs.io_wbs_datwr = '0;
        rst_n = 1'b0;
        idle(3);
        #1;
        check("rst_ack",   {31'd0, wbs.io_wbs_ack}, 32'd0);
        check("rst_datrd", wbs.io_wbs_datrd, 32'd0);
        check("rst_csb",   {30'd0, csb0_mem1, csb0_mem0}, 32'd3);
        check("rst_web",   {31'd0, web0}, 32'd1);
        check("rst_wmask", {28'd0, wmask0}, 32'd0);
        check("rst_addr",  {23'd0, addr0}, 32'd0);
        check("rst_din",   din0, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Miss held for 10 cycles: no strobe, no ack.
        @(posedge clk); #1;
        wbs.io_wbs_cyc = 1; wbs.io_wbs_stb = 1; wbs.io_wbs_we = 1;
        wbs.io_wbs_adr = 32'h3000_0000; wbs.io_wbs_sel = 4'hF;
        repeat (10) begin
            @(negedge clk);
            check("miss_csb", {30'd0, csb0_mem1, csb0_mem0}, 32'd3);
        end
        wbs.io_wbs_cyc = 0; wbs.io_wbs_stb = 0;
        idle(2);

        // Full-word write to bank 1, word 1.
        req(1'b1, 32'h3010_0804, 4'hF, 32'hDEAD_BEEF, s);
        expect_ack(s, 1'b0, '0);
        check("wr_csb1",  {31'd0, csb0_mem1}, 32'd0);
        check("wr_csb0",  {31'd0, csb0_mem0}, 32'd1);
        check("wr_web",   {31'd0, web0}, 32'd0);
        check("wr_addr",  {23'd0, addr0}, 32'd1);
        check("wr_wmask", {28'd0, wmask0}, 32'hF);
        check("wr_din",   din0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("wr_idle_csb", {30'd0, csb0_mem1, csb0_mem0}, 32'd3);
        check("wr_idle_web", {31'd0, web0}, 32'd1);
        check("wr_hold_din", din0, 32'hDEAD_BEEF);
        idle(2);

        // Read bank 0, word 4.
        req(1'b0, 32'h3010_0010, 4'hF, '0, s);
        expect_ack(s + RD_LAT, 1'b1, RB ? 32'h1234_5678 : 32'h0);
        check("rd_csb0", {31'd0, csb0_mem0}, RB ? 32'd0 : 32'd1);
        check("rd_csb1", {31'd0, csb0_mem1}, 32'd1);
        check("rd_web",  {31'd0, web0}, 32'd1);
        check("rd_wmask", {28'd0, wmask0}, 32'd0);
        if (RB) check("rd_addr", {23'd0, addr0}, 32'd4);
        idle(5);

        // Byte-lane 1 write to zeroed word 0, then read it back.
        req(1'b1, 32'h3010_0000, 4'h2, 32'hAABB_CCDD, s);
        expect_ack(s, 1'b0, '0);
        check("bw_wmask", {28'd0, wmask0}, 32'h2);
        idle(2);
        req(1'b0, 32'h3010_0003, 4'h1, '0, s);
        expect_ack(s + RD_LAT, 1'b1, RB ? 32'h0000_CC00 : 32'h0);
        idle(5);

        // sel==0 write is acked but leaves the word untouched.
        req(1'b1, 32'h3010_0010, 4'h0, 32'hFFFF_FFFF, s);
        expect_ack(s, 1'b0, '0);
        check("sel0_wmask", {28'd0, wmask0}, 32'd0);
        check("sel0_web",   {31'd0, web0}, 32'd0);
        check("datrd_hold", wbs.io_wbs_datrd, RB ? 32'h0000_CC00 : 32'h0);
        idle(2);
        req(1'b0, 32'h3010_0010, 4'hF, '0, s);
        expect_ack(s + RD_LAT, 1'b1, RB ? 32'h1234_5678 : 32'h0);
        idle(5);

        // Reset in the middle of a read: dropped, never acked.
        req(1'b0, 32'h3010_0804, 4'hF, '0, s);
`ifdef WFG_MEM_WRITER_READBACK_EN
        @(posedge clk); #1;
`endif
        rst_n = 1'b0;
        #1;
        check("midrst_csb",   {30'd0, csb0_mem1, csb0_mem0}, 32'd3);
        check("midrst_ack",   {31'd0, wbs.io_wbs_ack}, 32'd0);
        check("midrst_datrd", wbs.io_wbs_datrd, 32'd0);
        idle(2);
        #1 rst_n = 1'b1;
        idle(2);
        req(1'b0, 32'h3010_0804, 4'hF, '0, s);
        expect_ack(s + RD_LAT, 1'b1, RB ? 32'hDEAD_BEEF : 32'h0);
        check("post_rst_csb1", {31'd0, csb0_mem1}, RB ? 32'd0 : 32'd1);
        idle(5);

        idle(3);
        check("pending_acks", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wfg_mem_writer.md
# wfg_mem_writer

Wishbone slave that fills the waveform-pattern memory through port 0 (1RW) of the two 32x512 pattern SRAM macros. Port 1 of each macro is the read path used by the waveform generator; this block is the write end of the same memory. It decodes a 4 KiB window, selects one of the two banks, and drives the SRAM write strobes with byte masks. Optional read-back returns SRAM contents over Wishbone.

## Interface
Parameters:
- BASE_ADDR, 32'h3010_0000, window base; `io_wbs_adr[31:12]` is compared against `BASE_ADDR[31:12]`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- io_wbs_clk  in  1  clock; also clocks SRAM port 0.
- io_wbs_rst_n  in  1  asynchronous active-low reset.
- io_wbs_cyc, io_wbs_stb, io_wbs_we  in  1  Wishbone classic strobes.
- io_wbs_sel  in  4  byte selects.
- io_wbs_adr  in  32  byte address.
- io_wbs_datwr  in  32  write data.
- io_wbs_datrd  out  32  read data.
- io_wbs_ack  out  1  single-cycle acknowledge.
- csb0_mem0, csb0_mem1  out  1  active-low chip select, bank 0 / bank 1.
- web0  out  1  active-low write enable, shared by both banks.
- wmask0  out  4  byte write mask, shared.
- addr0  out  9  word address within a bank, shared.
- din0  out  32  write data, shared.
- dout0_mem0, dout0_mem1  in  32  port-0 read data, bank 0 / bank 1.

## Operation
- Hit: `cyc & stb & (adr[31:12] == BASE_ADDR[31:12])`, sampled only in IDLE.
  - A miss is never acked.
  - `adr[1:0]` is ignored.
- Bank select: `adr[11]` (0 = mem0, 1 = mem1).
- Word address: `addr0 = adr[10:2]`.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, ACK.
  - IDLE + hit + we -> WR: drive the selected csb0 low, `web0` low, `wmask0 = sel`, `din0 = datwr`, `addr0`; assert `io_wbs_ack`. Next state is IDLE.
  - IDLE + hit + !we -> RD_ISSUE: drive the selected csb0 low, `web0` high, `wmask0 = 0`, `addr0`.
  - RD_ISSUE -> RD_WAIT: all csb0 high; a bank register remembers the selected bank.
  - RD_WAIT -> ACK: capture `dout0_mem0` or `dout0_mem1` (per the bank register) into `io_wbs_datrd`.
  - ACK: `io_wbs_ack` high for one cycle, then IDLE.
- Only one csb0 is ever low, and only in WR or RD_ISSUE.
- All SRAM outputs are registered. Outside WR/RD_ISSUE: csb0 high, `web0` high, `wmask0 = 0`; `addr0` and `din0` hold their last values.
- `sel == 0` write: the access still runs with `wmask0 = 0` (memory unchanged) and is acked.
- Reads return the full word regardless of `sel`.
- `io_wbs_datrd` holds its value until the next read completes.
- The master dropping `stb` mid-read does not abort the access; ack is still issued in ACK and is ignored by the master.

## Timing
- Request sampled in cycle N.
- Write: strobes and ack both in N+1; the SRAM captures at the end of N+1. Write latency is 1 cycle; back-to-back writes are possible every 2 cycles.
- Read: strobe in N+1; SRAM data valid in N+2 and captured at the end of N+2; ack with data in N+3. Read latency is 3 cycles.
- Reset values: `io_wbs_ack` 0, `io_wbs_datrd` 0, both csb0 1, `web0` 1, `wmask0` 0, `addr0` 0, `din0` 0, FSM IDLE.
- Reset asserted mid-access: all outputs go to reset values immediately (asynchronous). The in-flight transaction is dropped and never acked.
- No interaction with port 1. Same-address, same-cycle write/read contention between ports is the software's responsibility: the generator must be stopped while memory is written.

## Configuration
- `WFG_MEM_WRITER_READBACK_EN` defined: reads behave as above (RD_ISSUE/RD_WAIT/ACK, 3-cycle latency, SRAM data).
- Not defined:
  - Reads skip the SRAM: IDLE + hit + !we goes straight to ACK, acks in N+1 with `io_wbs_datrd = 0`.
  - csb0 is never asserted for reads.
  - `dout0_mem*` are unused, and the RD_ISSUE/RD_WAIT states are removed.

## Structure
- Shared package `wfg_mem_pkg` holds:
  - FSM state enum;
  - `BANK_ADDR_W = 9`, `DATA_W = 32`, `SEL_W = 4`, `BANK_SEL_BIT = 11`, `WINDOW_MSB_LSB = 12`.
- Single flat module; no sub-module. Decode and FSM are small enough to stay inline.

## Test plan
- Reset then idle:
  - all outputs at reset values, no ack;
  - access to `0x3000_0000` (miss) -> no csb0 low, no ack for 10 cycles.
- Write `0x3010_0804`, data `0xDEADBEEF`, `sel 0xF`:
  - in N+1: `csb0_mem1 = 0`, `csb0_mem0 = 1`, `web0 = 0`, `addr0 = 1`, `wmask0 = 0xF`, `din0 = 0xDEADBEEF`, ack = 1;
  - IDLE in N+2.
- Read `0x3010_0010` with `dout0_mem0` model returning `0x12345678` (READBACK_EN):
  - `csb0_mem0 = 0`, `web0 = 1`, `addr0 = 4` in N+1;
  - ack with `datrd = 0x12345678` in N+3.
- Byte write `sel 0x2`, data `0xAABBCCDD` to word 0, then read back via SRAM model -> only byte 1 changed (`0x0000CC00` from a zeroed word).
- `sel = 0` write -> `wmask0 = 0`, ack in N+1; SRAM contents unchanged.
- Reset pulse in RD_WAIT:
  - csb0 high, ack 0, `datrd = 0` immediately;
  - the next read after reset completes normally with 3-cycle latency.
- Without READBACK_EN: read of `0x3010_0000` -> ack in N+1, `datrd = 0`, no csb0 asserted.
